hamming_secded_encoder: RTL and testbench

- Streaming, parametrised Hamming encoder: any DATA_W, optional SECDED overall-parity bit.
- Valid/ready handshake on both sides, backed by a 2-entry skid stage, so it sustains full throughput under backpressure.
- Per-beat single-bit error injection lets downstream decoders be exercised in-system.
- Sits between a data source and the channel/memory write path.

---
 rtl/hamming_pkg.sv | 54 +++++
 rtl/hamming_skid_buffer.sv | 52 +++++
 rtl/hamming_secded_encoder.sv | 93 +++++++++
 tb/tb_hamming_secded_encoder.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared Hamming code helpers: parity sizing, data-bit positions and a generic
// parity generator used by the streaming encoder.
package hamming_pkg;

    localparam int MAX_DATA_W   = 128;
    localparam int MAX_PARITY_W = 8;
    localparam int PARITY_LSB   = 0;

    // Smallest P with 2^P >= data_w + P + 1; descending scan keeps the loop bounded.
    function automatic int parity_w(input int data_w);
        int result;
        result = 0;
        for (int p = 12; p >= 1; p--) begin
            if ((1 << p) >= data_w + p + 1) begin
                result = p;
            end
        end
        return result;
    endfunction

    // Data bit i lands after i+1 data slots plus every power-of-two slot below it.
    function automatic int data_pos(input int i);
        return i + 1 + parity_w(i + 1);
    endfunction

    function automatic int data_lsb(input int p_w);
        return PARITY_LSB + p_w;
    endfunction

    function automatic int overall_idx(input int data_w, input int p_w);
        return data_w + p_w;
    endfunction

    function automatic logic [MAX_PARITY_W-1:0] hamming_parity(
        input logic [MAX_DATA_W-1:0] data,
        input int                    data_w
    );
        logic [MAX_PARITY_W-1:0] p;
        int                      pos;
        p = '0;
        for (int i = 0; i < MAX_DATA_W; i++) begin
            if (i < data_w) begin
                pos = data_pos(i);
                for (int j = 0; j < MAX_PARITY_W; j++) begin
                    if (pos[j]) begin
                        p[j] = p[j] ^ data[i];
                    end
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/hamming_skid_buffer.sv
// Two-entry valid/ready stage (main + skid) giving full throughput with a
// registered in_ready, so there is no combinational path from i_out_ready.
module hamming_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);
    logic [WIDTH-1:0] r_main_data;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_main_valid;
    logic             r_skid_valid;
    logic             w_in_fire;
    logic             w_main_free;

    assign o_ready     = !r_skid_valid && !rst;
    assign w_in_fire   = i_valid && o_ready;
    assign w_main_free = !r_main_valid || i_ready;
    assign o_data      = r_main_data;
    assign o_valid     = r_main_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_data  <= '0;
            r_skid_data  <= '0;
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_main_free) begin
            // A parked skid word always goes out before any newly accepted beat.
            if (r_skid_valid) begin
                r_main_data  <= r_skid_data;
                r_main_valid <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_main_data  <= i_data;
                r_main_valid <= 1'b1;
            end else begin
                r_main_valid <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_skid_data  <= i_data;
            r_skid_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/hamming_secded_encoder.sv
// Streaming systematic Hamming SEC/SECDED encoder with per-beat single-bit
// error injection, a skid-buffered output and a wrapping output word counter.
module hamming_secded_encoder
    import hamming_pkg::*;
#(
    parameter int  DATA_W   = 4,
    parameter int  SECDED   = 1,
    parameter int  CNT_W    = 16,
    localparam int PARITY_W = parity_w(DATA_W),
    localparam int CW_W     = DATA_W + PARITY_W + SECDED,
    localparam int IDX_W    = (CW_W > 1) ? $clog2(CW_W) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              inj_en,
    input  logic [IDX_W-1:0]  inj_bit,
    output logic [CW_W-1:0]   out_codeword,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  word_cnt
);
    localparam int SYS_W    = DATA_W + PARITY_W;
    localparam int DATA_LSB = data_lsb(PARITY_W);

    logic [MAX_DATA_W-1:0]   w_data_ext;
    logic [MAX_PARITY_W-1:0] w_parity_ext;
    logic                    w_unused_parity;
    logic [SYS_W-1:0]        w_sys_cw;
    logic [CW_W-1:0]         w_enc_cw;
    logic [CW_W-1:0]         w_flip_mask;
    logic [CW_W-1:0]         w_inj_cw;
    logic                    w_out_fire;
    logic [CNT_W-1:0]        r_word_cnt;

    always_comb begin
        w_data_ext                = '0;
        w_data_ext[DATA_W-1:0]    = in_data;
    end

    assign w_parity_ext    = hamming_parity(w_data_ext, DATA_W);
    assign w_unused_parity = ^w_parity_ext[MAX_PARITY_W-1:PARITY_W];

    assign w_sys_cw[PARITY_LSB +: PARITY_W] = w_parity_ext[PARITY_W-1:0];
    assign w_sys_cw[DATA_LSB +: DATA_W]     = in_data;

    generate
        if (SECDED != 0) begin : g_secded
            // Even parity across the whole word, so the overall bit is the XOR of the rest.
            assign w_enc_cw[SYS_W-1:0]                       = w_sys_cw;
            assign w_enc_cw[overall_idx(DATA_W, PARITY_W)]   = ^w_sys_cw;
        end else begin : g_sec
            assign w_enc_cw = w_sys_cw;
        end
    endgenerate

    // Out-of-range inj_bit matches no lane, so nothing is flipped.
    generate
        for (genvar gi = 0; gi < CW_W; gi++) begin : g_flip
            assign w_flip_mask[gi] = inj_en && (inj_bit == IDX_W'(gi));
        end
    endgenerate

    assign w_inj_cw = w_enc_cw ^ w_flip_mask;

    hamming_skid_buffer #(
        .WIDTH(CW_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_data  (w_inj_cw),
        .i_valid (in_valid),
        .o_ready (in_ready),
        .o_data  (out_codeword),
        .o_valid (out_valid),
        .i_ready (out_ready)
    );

    assign w_out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word_cnt <= '0;
        end else if (w_out_fire) begin
            r_word_cnt <= r_word_cnt + CNT_W'(1);
        end
    end

    assign word_cnt = r_word_cnt;

endmodule

// File: tb/tb_hamming_secded_encoder.sv
// Self-checking bench: known-vector table, backpressure and reset sequences,
// a counter-wrap instance and a randomized multi-width sweep with scoreboards.
module tb_hamming_secded_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] d;
        logic       ie;
        logic [2:0] ib;
        logic [7:0] exp;
    } vec_t;

    typedef struct packed {
        logic [71:0] cw;
        logic        chk;
    } sb_t;

    function automatic int ref_pw(input int dw);
        int p;
        p = 1;
        while ((1 << p) < dw + p + 1) p++;
        return p;
    endfunction

    // Reference: scatter data into classic Hamming positions, compute parity, then pack systematically.
    function automatic logic [71:0] ref_encode(input logic [63:0] d, input int dw, input int sd);
        logic [127:0] h;
        logic [71:0]  cw;
        logic         b;
        int           pos, k, pw;
        h = '0; cw = '0; k = 0; pos = 0; pw = ref_pw(dw);
        while (k < dw) begin
            pos++;
            if ((pos & (pos - 1)) != 0) begin
                h[pos] = d[k];
                k++;
            end
        end
        for (int j = 0; j < pw; j++) begin
            b = 1'b0;
            for (int q = 1; q < 128; q++) if (q[j]) b = b ^ h[q];
            cw[j] = b;
        end
        for (int i = 0; i < dw; i++) cw[pw + i] = d[i];
        if (sd != 0) cw[pw + dw] = ^cw;
        return cw;
    endfunction

    function automatic int syndrome(input logic [71:0] w, input int dw);
        int pw, pos, k, s;
        pw = ref_pw(dw); s = 0; k = 0; pos = 0;
        for (int j = 0; j < pw; j++) if (w[j]) s = s ^ (1 << j);
        while (k < dw) begin
            pos++;
            if ((pos & (pos - 1)) != 0) begin
                if (w[pw + k]) s = s ^ pos;
                k++;
            end
        end
        return s;
    endfunction

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // ---------------- main DUT (DATA_W=4, SECDED=1) ----------------
    logic       rst = 1'b1;
    logic [3:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       inj_en = 1'b0;
    logic [2:0] inj_bit = '0;
    logic [7:0] out_codeword;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [15:0] word_cnt;
    logic [7:0] exp_q[$];

    hamming_secded_encoder #(.DATA_W(4), .SECDED(1), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .inj_en(inj_en), .inj_bit(inj_bit), .out_codeword(out_codeword),
        .out_valid(out_valid), .out_ready(out_ready), .word_cnt(word_cnt)
    );

    always @(negedge clk) begin : sb_main
        logic [71:0] full;
        logic [7:0]  e;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_main_unexpected got=%h", out_codeword);
                end else begin
                    e = exp_q.pop_front();
                    if (out_codeword !== e) begin
                        errors++;
                        $display("FAIL sb_main_word got=%h exp=%h", out_codeword, e);
                    end
                end
            end
            if (in_valid && in_ready) begin
                full = ref_encode({60'b0, in_data}, 4, 1);
                if (inj_en && int'(inj_bit) < 8) full[inj_bit] = ~full[inj_bit];
                exp_q.push_back(full[7:0]);
            end
        end
        $display("beat t=%0t in_fire=%0b d=%h out_fire=%0b cw=%h cnt=%0d", $time,
                 in_valid && in_ready && !rst, in_data, out_valid && out_ready && !rst, out_codeword, word_cnt);
    end

    vec_t vt[7];

    task automatic apply_vec(input int i);
        @(posedge clk); #1;
        in_data = vt[i].d; inj_en = vt[i].ie; inj_bit = vt[i].ib; in_valid = 1'b1;
        @(negedge clk);
        check("vec_in_ready", 72'(in_ready), 72'(1));
        @(posedge clk); #1;
        in_valid = 1'b0; inj_en = 1'b0;
        @(negedge clk);
        check("vec_out_valid", 72'(out_valid), 72'(1));
        check("vec_codeword", 72'(out_codeword), 72'(vt[i].exp));
    endtask

    task automatic send(input logic [3:0] d);
        bit acc;
        acc = 1'b0;
        in_data = d; in_valid = 1'b1; inj_en = 1'b0;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
        end
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send_timeout data=%h", d);
        end
    endtask

    // ---------------- counter-wrap DUT (CNT_W=4) ----------------
    logic       rst_s = 1'b1;
    logic       c_in_valid = 1'b0;
    logic       c_in_ready;
    logic [7:0] c_cw;
    logic       c_out_valid;
    logic [3:0] c_cnt;

    hamming_secded_encoder #(.DATA_W(4), .SECDED(1), .CNT_W(4)) u_dut_cnt (
        .clk(clk), .rst(rst_s), .in_data(4'h5), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .inj_en(1'b0), .inj_bit(3'd0), .out_codeword(c_cw),
        .out_valid(c_out_valid), .out_ready(1'b1), .word_cnt(c_cnt)
    );

    // ---------------- randomized width sweep ----------------
    for (genvar gi = 0; gi < 6; gi++) begin : g_sw
        localparam int DW = (gi < 2) ? 11 : (gi < 4) ? 32 : 64;
        localparam int SD = gi % 2;
        localparam int CW = ((gi < 2) ? 15 : (gi < 4) ? 38 : 71) + SD;
        localparam int IW = $clog2(CW);

        logic [DW-1:0] d = '0;
        logic          v = 1'b0;
        logic          rdy;
        logic          ie = 1'b0;
        logic [IW-1:0] ib = '1;
        logic [CW-1:0] cw;
        logic          ov;
        logic          ordy = 1'b0;
        logic [15:0]   cnt;
        sb_t           q[$];
        int            npop = 0;
        bit            done = 1'b0;

        hamming_secded_encoder #(.DATA_W(DW), .SECDED(SD), .CNT_W(16)) u_dut_sw (
            .clk(clk), .rst(rst_s), .in_data(d), .in_valid(v), .in_ready(rdy),
            .inj_en(ie), .inj_bit(ib), .out_codeword(cw),
            .out_valid(ov), .out_ready(ordy), .word_cnt(cnt)
        );

        always @(posedge clk) begin
            #1 ordy = ($urandom_range(0, 3) != 0);
        end

        always @(negedge clk) begin : mon
            sb_t         e;
            logic [71:0] full;
            logic [63:0] dz;
            bit          bad;
            if (rst_s) begin
                q.delete();
            end else begin
                if (ov && ordy) begin
                    checks++;
                    npop++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL sw%0d_unexpected got=%h", gi, cw);
                    end else begin
                        e = q.pop_front();
                        if (cw !== e.cw[CW-1:0]) begin
                            errors++;
                            $display("FAIL sw%0d_word got=%h exp=%h", gi, cw, e.cw[CW-1:0]);
                        end
                        if (e.chk) begin
                            full = '0;
                            full[CW-1:0] = cw;
                            bad = (syndrome(full, DW) != 0) || ((SD != 0) && (^cw));
                            checks++;
                            if (bad) begin
                                errors++;
                                $display("FAIL sw%0d_syndrome_parity syn=%0d par=%0b", gi, syndrome(full, DW), ^cw);
                            end
                        end
                    end
                end
                if (v && rdy) begin
                    dz = '0;
                    dz[DW-1:0] = d;
                    full = ref_encode(dz, DW, SD);
                    e.chk = 1'b1;
                    if (ie && int'(ib) < CW) begin
                        full[ib] = ~full[ib];
                        e.chk = 1'b0;
                    end
                    e.cw = full;
                    q.push_back(e);
                end
            end
        end

        initial begin : drv
            logic [63:0] r;
            bit          acc;
            @(negedge rst_s);
            @(posedge clk); #1;
            for (int n = 0; n < 40; n++) begin
                r = {$urandom(), $urandom()};
                d = r[DW-1:0]; v = 1'b1; ie = (n == 0); ib = '1;
                acc = 1'b0;
                for (int t = 0; t < 100 && !acc; t++) begin
                    @(negedge clk);
                    acc = rdy;
                    @(posedge clk); #1;
                end
                if (!acc) begin
                    checks++; errors++;
                    $display("FAIL sw%0d_accept_timeout beat=%0d", gi, n);
                end
                v = 1'b0; ie = 1'b0;
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                end
            end
            for (int t = 0; t < 300 && q.size() != 0; t++) @(negedge clk);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL sw%0d_drain got=%0d exp=0", gi, q.size());
            end
            checks++;
            if (int'(cnt) != npop) begin
                errors++;
                $display("FAIL sw%0d_word_cnt got=%0d exp=%0d", gi, cnt, npop);
            end
            done = 1'b1;
        end
    end

    // ---------------- directed sequences ----------------
    initial begin : main_seq
        bit all_done;
        vt[0] = '{4'h0, 1'b0, 3'd0, 8'h00};
        vt[1] = '{4'h1, 1'b0, 3'd0, 8'h8B};
        vt[2] = '{4'hB, 1'b0, 3'd0, 8'h59};
        vt[3] = '{4'hF, 1'b0, 3'd0, 8'hFF};
        vt[4] = '{4'hB, 1'b1, 3'd7, 8'hD9};
        vt[5] = '{4'hB, 1'b1, 3'd0, 8'h58};
        vt[6] = '{4'hB, 1'b0, 3'd7, 8'h59};

        // Reset held 3 cycles with a beat offered: nothing gets in.
        rst = 1'b1; in_valid = 1'b1; in_data = 4'hF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_out_valid", 72'(out_valid), 72'(0));
            check("rst_in_ready", 72'(in_ready), 72'(0));
            check("rst_word_cnt", 72'(word_cnt), 72'(0));
            check("rst_codeword", 72'(out_codeword), 72'(0));
        end
        @(posedge clk); #1;
        rst = 1'b0; rst_s = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 72'(in_ready), 72'(1));
        check("post_rst_out_valid", 72'(out_valid), 72'(0));

        for (int i = 0; i < 4; i++) apply_vec(i);
        @(posedge clk);
        @(negedge clk);
        check("cnt_after_4", 72'(word_cnt), 72'(4));
        for (int i = 4; i < 7; i++) apply_vec(i);
        @(posedge clk); #1;
        check("cnt_after_7", 72'(word_cnt), 72'(7));

        // Backpressure: two beats fill main+skid, third waits.
        out_ready = 1'b0;
        fork
            begin
                send(4'h1); send(4'h2); send(4'h3);
                in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready_low", 72'(in_ready), 72'(0));
                for (int s = 0; s < 3; s++) begin
                    check("bp_hold_valid", 72'(out_valid), 72'(1));
                    check("bp_hold_word", 72'(out_codeword), 72'(8'h8B));
                    @(negedge clk);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("bp_none_lost", 72'(exp_q.size()), 72'(0));
        check("bp_word_cnt", 72'(word_cnt), 72'(10));

        // Reset with the skid full discards both words.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(4'h4); send(4'h5);
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_skid_full", 72'(in_ready), 72'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 72'(out_valid), 72'(0));
        check("midrst_in_ready", 72'(in_ready), 72'(1));
        check("midrst_word_cnt", 72'(word_cnt), 72'(0));
        out_ready = 1'b1;
        apply_vec(2);

        // 17 transfers on a 4-bit counter wraps to 1.
        @(posedge clk); #1;
        c_in_valid = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("wrap_mid_valid", 72'(c_out_valid), 72'(1));
        check("wrap_mid_word", 72'(c_cw), 72'(8'h2D));
        check("wrap_mid_cnt", 72'(c_cnt), 72'(4));
        repeat (12) @(posedge clk);
        #1 c_in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("wrap_cnt", 72'(c_cnt), 72'(1));
        check("wrap_idle_valid", 72'(c_out_valid), 72'(0));
        check("wrap_in_ready", 72'(c_in_ready), 72'(1));

        all_done = 1'b0;
        for (int t = 0; t < 5000 && !all_done; t++) begin
            @(posedge clk);
            all_done = g_sw[0].done && g_sw[1].done && g_sw[2].done &&
                       g_sw[3].done && g_sw[4].done && g_sw[5].done;
        end
        if (!all_done) begin
            checks++; errors++;
            $display("FAIL sweep_timeout got=0 exp=1");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
